// File: rtl/rz_pkg.sv
// Shared constants, mode encodings and FSM states for the rotozoom coordinate generator.
package rz_pkg;

    localparam int RZ_COORD_W    = 11;
    localparam int RZ_FRAC_W     = 13;
    localparam int RZ_ANGLE_BITS = 8;
    localparam int RZ_ZOOM_W     = 8;
    localparam int RZ_ZOOM_FRAC  = 6;

    localparam int ACC_W   = RZ_COORD_W + RZ_FRAC_W;
    localparam int QUARTER = 1 << (RZ_ANGLE_BITS - 2);

    typedef enum logic [1:0] {
        RZ_AUTO   = 2'd0,
        RZ_MANUAL = 2'd1,
        RZ_PULSE  = 2'd2,
        RZ_FREEZE = 2'd3
    } rz_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MUL,
        ST_DONE
    } rz_state_e;

endpackage

// File: rtl/rz_sine_lut.sv
// Combinational sine lookup folded from a quarter-wave table; +1.0 is 1<<FRAC_W exactly.
module rz_sine_lut #(
    parameter int ANGLE_BITS = 8,
    parameter int FRAC_W     = 13
) (
    input  logic        [ANGLE_BITS-1:0] angle_i,
    output logic signed [FRAC_W+1:0]     sin_o
);

    localparam int QBITS = ANGLE_BITS - 2;

    // Quarter wave 0..90 deg inclusive, 64 steps, 13 fraction bits (the default geometry).
    localparam int QTAB [65] = '{
           0,  201,  402,  603,  803, 1003, 1202, 1401,
        1598, 1795, 1990, 2185, 2378, 2570, 2760, 2948,
        3135, 3320, 3503, 3683, 3862, 4038, 4212, 4383,
        4551, 4717, 4880, 5040, 5197, 5351, 5501, 5649,
        5793, 5933, 6070, 6203, 6333, 6458, 6580, 6698,
        6811, 6921, 7027, 7128, 7225, 7317, 7405, 7489,
        7568, 7643, 7713, 7779, 7839, 7895, 7946, 7993,
        8035, 8071, 8103, 8130, 8153, 8170, 8182, 8190,
        8192
    };

    logic [1:0]        quad;
    logic [QBITS-1:0]  rem;
    logic [QBITS:0]    idx;
    logic [FRAC_W+1:0] mag;

    always_comb begin
        quad = angle_i[ANGLE_BITS-1 -: 2];
        rem  = angle_i[QBITS-1:0];
        // Odd quadrants read the table mirrored; quadrant 1 with rem=0 hits the exact +1.0 entry.
        idx  = quad[0] ? ({1'b1, {QBITS{1'b0}}} - {1'b0, rem}) : {1'b0, rem};
        mag  = (FRAC_W+2)'(QTAB[idx]);
        sin_o = quad[1] ? -signed'(mag) : signed'(mag);
    end

endmodule

// File: rtl/rotozoom_coord_gen.sv
// Affine rotate/zoom texture-coordinate generator: per-frame coefficient FSM plus per-pixel accumulators.
module rotozoom_coord_gen
    import rz_pkg::*;
#(
    parameter int COORD_W    = RZ_COORD_W,
    parameter int FRAC_W     = RZ_FRAC_W,
    parameter int ANGLE_BITS = RZ_ANGLE_BITS,
    parameter int ZOOM_W     = RZ_ZOOM_W,
    parameter int ZOOM_FRAC  = RZ_ZOOM_FRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      line_start,
    input  logic                      pix_active,
    input  logic                      vblank_start,
    input  logic [1:0]                mode,
    input  logic [2:0]                speed,
    input  logic [ANGLE_BITS-1:0]     angle_in,
    input  logic [ZOOM_W-1:0]         zoom_in,
    output logic signed [COORD_W-1:0] u,
    output logic signed [COORD_W-1:0] v,
    output logic                      uv_valid,
    output logic [ANGLE_BITS-1:0]     angle,
    output logic                      busy,
    output logic                      coef_stale
);

    localparam int ACC_BITS = COORD_W + FRAC_W;
    localparam int PROD_W   = ACC_BITS + ZOOM_W;
    localparam int CNT_W    = $clog2(ZOOM_W);
    localparam int ZS_W     = FRAC_W + 3;
    localparam int ZOOM_ONE = 1 << ZOOM_FRAC;
    localparam int ZOOM_MAX = (1 << ZOOM_W) - 1;
    localparam logic signed [ACC_BITS-1:0] ONE = ACC_BITS'(1 << FRAC_W);

    rz_state_e                   state_q, state_d;
    logic [ANGLE_BITS-1:0]       angle_q, angle_d;
    logic [ZOOM_W-1:0]           zoom_q, zoom_eff;
    logic [CNT_W-1:0]            cnt_q;
    logic signed [PROD_W-1:0]    mc_s_q, mc_c_q, pr_s_q, pr_c_q;
    logic signed [ACC_BITS-1:0]  sh_cn_q, sh_sn_q, cn_q, sn_q;
    logic signed [ACC_BITS-1:0]  row_u_q, row_v_q, pix_u_q, pix_v_q;
    logic                        stale_q, valid_q;
    logic signed [FRAC_W+1:0]    sin_val, cos_val;
    logic signed [ZS_W-1:0]      zsum;

    rz_sine_lut #(.ANGLE_BITS(ANGLE_BITS), .FRAC_W(FRAC_W)) u_sin (
        .angle_i (angle_q),
        .sin_o   (sin_val)
    );

    rz_sine_lut #(.ANGLE_BITS(ANGLE_BITS), .FRAC_W(FRAC_W)) u_cos (
        .angle_i (angle_q + ANGLE_BITS'(1 << (ANGLE_BITS - 2))),
        .sin_o   (cos_val)
    );

    always_comb begin
        angle_d = angle_q;
        if (vblank_start) begin
            unique case (rz_mode_e'(mode))
                RZ_AUTO, RZ_PULSE: angle_d = angle_q + ANGLE_BITS'(speed) + ANGLE_BITS'(1);
                RZ_MANUAL:         angle_d = angle_in;
                default:           angle_d = angle_q;
            endcase
        end
    end

    always_comb begin
        zsum     = ZS_W'(ZOOM_ONE) + ZS_W'(sin_val >>> (FRAC_W - ZOOM_FRAC + 1));
        zoom_eff = (zoom_in == '0) ? ZOOM_W'(1) : zoom_in;
        if (rz_mode_e'(mode) == RZ_PULSE) begin
            if (zsum < ZS_W'(1))             zoom_eff = ZOOM_W'(1);
            else if (zsum > ZS_W'(ZOOM_MAX)) zoom_eff = '1;
            else                             zoom_eff = zsum[ZOOM_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (vblank_start) state_d = ST_LOOKUP;
            ST_LOOKUP: state_d = ST_MUL;
            ST_MUL:    if (cnt_q == CNT_W'(ZOOM_W - 1)) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every register below uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            angle_q <= '0;
            zoom_q  <= '0;
            cnt_q   <= '0;
            mc_s_q  <= '0;
            mc_c_q  <= '0;
            pr_s_q  <= '0;
            pr_c_q  <= '0;
            sh_cn_q <= ONE;
            sh_sn_q <= '0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            unique case (state_q)
                ST_LOOKUP: begin
                    mc_s_q <= PROD_W'(sin_val);
                    mc_c_q <= PROD_W'(cos_val);
                    pr_s_q <= '0;
                    pr_c_q <= '0;
                    zoom_q <= zoom_eff;
                    cnt_q  <= '0;
                end
                ST_MUL: begin
                    // LSB-first shift-add; the zoom multiplier is unsigned so no sign correction.
                    if (zoom_q[0]) begin
                        pr_s_q <= pr_s_q + mc_s_q;
                        pr_c_q <= pr_c_q + mc_c_q;
                    end
                    mc_s_q <= mc_s_q <<< 1;
                    mc_c_q <= mc_c_q <<< 1;
                    zoom_q <= zoom_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                ST_DONE: begin
                    sh_sn_q <= ACC_BITS'(pr_s_q >>> ZOOM_FRAC);
                    sh_cn_q <= ACC_BITS'(pr_c_q >>> ZOOM_FRAC);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cn_q    <= ONE;
            sn_q    <= '0;
            stale_q <= 1'b0;
            row_u_q <= '0;
            row_v_q <= '0;
            pix_u_q <= '0;
            pix_v_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pix_active;
            if (frame_start) begin
                if (state_q == ST_IDLE) begin
                    cn_q    <= sh_cn_q;
                    sn_q    <= sh_sn_q;
                    stale_q <= 1'b0;
                end else begin
                    stale_q <= 1'b1;
                end
                row_u_q <= '0;
                row_v_q <= '0;
                pix_u_q <= '0;
                pix_v_q <= '0;
            end else if (line_start) begin
                row_u_q <= row_u_q - sn_q;
                row_v_q <= row_v_q + cn_q;
                pix_u_q <= row_u_q - sn_q;
                pix_v_q <= row_v_q + cn_q;
            end else if (pix_active) begin
                pix_u_q <= pix_u_q + cn_q;
                pix_v_q <= pix_v_q + sn_q;
            end
        end
    end

    assign u          = pix_u_q[FRAC_W +: COORD_W];
    assign v          = pix_v_q[FRAC_W +: COORD_W];
    assign uv_valid   = valid_q;
    assign angle      = angle_q;
    assign busy       = (state_q != ST_IDLE);
    assign coef_stale = stale_q;

endmodule
